// File: rtl/pipe_sched.sv
// Hazard and sequencing controller for the 3-stage core: PC select, s1 stall/flush,
// post-reset boot sequencing, and the MMIO cycle/instret counters.

// Protocol checker: s2 must hold a bubble while the controller is killing fetches.
module pipe_sched_checker (
    input logic clk,
    input logic rst,
    input logic in_kill,
    input logic s2_valid
);
    kill_needs_bubble: assert property (@(posedge clk) disable iff (rst) in_kill |-> !s2_valid);
endmodule

module pipe_sched #(
    parameter int BOOT_CYCLES = 2,
    parameter int IMEM_LAT    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_s1,
    input  logic [31:0] inst_s2,
    input  logic        s2_valid,
    input  logic        s3_valid,
    input  logic        br_taken_s2,
    input  logic        br_pred_s2,
    input  logic        cnt_clr,
    output logic [1:0]  pc_sel,
    output logic        stall_s1,
    output logic        flush_s1,
    output logic        booting,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
);
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    localparam logic [1:0] PC_SEQ = 2'd0;
    localparam logic [1:0] PC_S2  = 2'd1;
    localparam logic [1:0] PC_JAL = 2'd2;
    localparam logic [1:0] PC_RST = 2'd3;

    localparam logic [1:0] KILL_INIT = 2'(IMEM_LAT);
    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

    typedef enum logic [1:0] {ST_RESET, ST_BOOT, ST_RUN, ST_KILL} state_t;

    state_t      state_r, state_next_s;
    logic [1:0]  kill_cnt_r, kill_cnt_next_s;
    logic [3:0]  boot_cnt_r, boot_cnt_next_s;
    logic [31:0] cycle_r, instret_r;

    // Field decode for the two stages this block inspects.
    logic [6:0] opc_s1_s, opc_s2_s;
    logic [4:0] rs1_s1_s, rs2_s1_s, rd_s2_s;
    logic       reads_rs1_s, reads_rs2_s;
    logic       redirect_s, load_use_s, jal_s1_s;
    logic       unused_bits_s;

    assign opc_s1_s = inst_s1[6:0];
    assign opc_s2_s = inst_s2[6:0];
    assign rs1_s1_s = inst_s1[19:15];
    assign rs2_s1_s = inst_s1[24:20];
    assign rd_s2_s  = inst_s2[11:7];
    assign unused_bits_s = ^{inst_s1[31:25], inst_s1[14:7], inst_s2[31:12]};

    assign reads_rs1_s = (opc_s1_s != OP_LUI) && (opc_s1_s != OP_AUIPC) && (opc_s1_s != OP_JAL);
    assign reads_rs2_s = (opc_s1_s == OP_REG) || (opc_s1_s == OP_STORE) || (opc_s1_s == OP_BRANCH);

    assign redirect_s = s2_valid &&
                        ((opc_s2_s == OP_JALR) ||
                         ((opc_s2_s == OP_BRANCH) && (br_taken_s2 != br_pred_s2)));
    assign load_use_s = s2_valid && (opc_s2_s == OP_LOAD) && (rd_s2_s != 5'd0) &&
                        ((reads_rs1_s && (rs1_s1_s == rd_s2_s)) ||
                         (reads_rs2_s && (rs2_s1_s == rd_s2_s)));
    assign jal_s1_s   = (opc_s1_s == OP_JAL);

    // Next-state and stage-control decisions; redirect beats load-use beats s1 JAL.
    always_comb begin
        state_next_s    = state_r;
        kill_cnt_next_s = kill_cnt_r;
        boot_cnt_next_s = boot_cnt_r;
        pc_sel          = PC_SEQ;
        stall_s1        = 1'b0;
        flush_s1        = 1'b0;
        booting         = 1'b0;
        case (state_r)
            ST_RESET: begin
                pc_sel          = PC_RST;
                stall_s1        = 1'b1;
                flush_s1        = 1'b1;
                booting         = 1'b1;
                kill_cnt_next_s = 2'd0;
                boot_cnt_next_s = 4'd0;
                state_next_s    = ST_BOOT;
            end
            ST_BOOT: begin
                pc_sel   = PC_RST;
                stall_s1 = 1'b1;
                flush_s1 = 1'b1;
                booting  = 1'b1;
                if (boot_cnt_r >= BOOT_LAST) begin
                    state_next_s = ST_RUN;
                end else begin
                    boot_cnt_next_s = boot_cnt_r + 4'd1;
                end
            end
            ST_RUN: begin
                if (redirect_s) begin
                    pc_sel   = PC_S2;
                    flush_s1 = 1'b1;
                    if (IMEM_LAT > 0) begin
                        state_next_s    = ST_KILL;
                        kill_cnt_next_s = KILL_INIT;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end else if (load_use_s) begin
                    stall_s1 = 1'b1;
                    flush_s1 = 1'b1;
                end else if (jal_s1_s) begin
                    pc_sel = PC_JAL;
                    if (IMEM_LAT > 0) begin
                        state_next_s    = ST_KILL;
                        kill_cnt_next_s = KILL_INIT;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end else begin
                    pc_sel = PC_SEQ;
                end
            end
            ST_KILL: begin
                // Fetches still in flight from the old path are squashed; s1 is stale.
                flush_s1 = 1'b1;
                if (kill_cnt_r <= 2'd1) begin
                    kill_cnt_next_s = 2'd0;
                    state_next_s    = ST_RUN;
                end else begin
                    kill_cnt_next_s = kill_cnt_r - 2'd1;
                end
            end
            default: begin
                pc_sel       = PC_RST;
                stall_s1     = 1'b1;
                flush_s1     = 1'b1;
                booting      = 1'b1;
                state_next_s = ST_RESET;
            end
        endcase
    end

    // FSM state, kill and boot counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_RESET;
            kill_cnt_r <= 2'd0;
            boot_cnt_r <= 4'd0;
        end else begin
            state_r    <= state_next_s;
            kill_cnt_r <= kill_cnt_next_s;
            boot_cnt_r <= boot_cnt_next_s;
        end
    end

    // Cycle and retired-instruction counters; clear wins over increment, hold while booting.
    always_ff @(posedge clk) begin
        if (rst || (state_r == ST_RESET)) begin
            cycle_r   <= 32'd0;
            instret_r <= 32'd0;
        end else if ((state_r == ST_RUN) || (state_r == ST_KILL)) begin
            if (cnt_clr) begin
                cycle_r   <= 32'd0;
                instret_r <= 32'd0;
            end else begin
                cycle_r   <= cycle_r + 32'd1;
                instret_r <= instret_r + {31'd0, s3_valid};
            end
        end else begin
            cycle_r   <= cycle_r;
            instret_r <= instret_r;
        end
    end

    assign cycle_cnt   = cycle_r;
    assign instret_cnt = instret_r;

    pipe_sched_checker u_chk (
        .clk      (clk),
        .rst      (rst),
        .in_kill  (state_r == ST_KILL),
        .s2_valid (s2_valid)
    );
endmodule

// File: tb/tb_pipe_sched.sv
// Directed bench for pipe_sched: vector table for RUN decisions plus hand sequences
// for boot, KILL, counters and reset during KILL/stall.
module tb_pipe_sched;
    localparam logic [31:0] NOP      = 32'h00000013;
    localparam logic [31:0] LW_X5    = 32'h0000A283; // lw x5,0(x1)
    localparam logic [31:0] LW_X0    = 32'h0000A003; // lw x0,0(x1)
    localparam logic [31:0] ADD_U5   = 32'h00728333; // add x6,x5,x7
    localparam logic [31:0] ADD_NO   = 32'h00740333; // add x6,x8,x7
    localparam logic [31:0] ADD_X0   = 32'h00700333; // add x6,x0,x7
    localparam logic [31:0] ADD_R2   = 32'h00538333; // add x6,x7,x5
    localparam logic [31:0] LUI_F5   = 32'h00028337; // lui, rs1 field = 5
    localparam logic [31:0] ADDI_U5  = 32'h00128313; // addi x6,x5,1
    localparam logic [31:0] ADDI_I5  = 32'h00540313; // addi x6,x8,5
    localparam logic [31:0] SW_X5    = 32'h00542023; // sw x5,0(x8)
    localparam logic [31:0] BEQ_S1   = 32'h00540063; // beq x8,x5
    localparam logic [31:0] BEQ_S2   = 32'h00208063; // beq x1,x2
    localparam logic [31:0] JALR     = 32'h00008067; // jalr x0,0(x1)
    localparam logic [31:0] JAL      = 32'h000000EF; // jal x1,0

    logic        clk = 1'b0;
    logic        rst, s2_valid, s3_valid, br_taken_s2, br_pred_s2, cnt_clr;
    logic [31:0] inst_s1, inst_s2;
    logic [1:0]  pc_sel;
    logic        stall_s1, flush_s1, booting;
    logic [31:0] cycle_cnt, instret_cnt;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] s1;
        logic [31:0] s2;
        logic        v;
        logic        tk;
        logic        pr;
        logic [1:0]  pc;
        logic        st;
        logic        fl;
    } vec_t;

    vec_t vecs [0:21];

    pipe_sched #(.BOOT_CYCLES(2), .IMEM_LAT(1)) dut (
        .clk(clk), .rst(rst), .inst_s1(inst_s1), .inst_s2(inst_s2),
        .s2_valid(s2_valid), .s3_valid(s3_valid), .br_taken_s2(br_taken_s2),
        .br_pred_s2(br_pred_s2), .cnt_clr(cnt_clr), .pc_sel(pc_sel),
        .stall_s1(stall_s1), .flush_s1(flush_s1), .booting(booting),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] s1, input logic [31:0] s2, input logic v,
                         input logic tk, input logic pr);
        inst_s1 = s1; inst_s2 = s2; s2_valid = v; br_taken_s2 = tk; br_pred_s2 = pr;
    endtask

    // Expected {pc_sel, stall_s1, flush_s1} packed into 4 bits.
    task automatic check_ctl(input string name, input logic [1:0] pc, input logic st, input logic fl);
        check(name, {28'd0, pc_sel, stall_s1, flush_s1}, {28'd0, pc, st, fl});
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        //          s1       s2      v     tk    pr    pc    st    fl
        vecs[0]  = '{NOP,     NOP,    1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[1]  = '{ADD_U5,  LW_X5,  1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1};
        vecs[2]  = '{ADD_NO,  LW_X5,  1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[3]  = '{ADD_X0,  LW_X0,  1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[4]  = '{ADD_R2,  LW_X5,  1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1};
        vecs[5]  = '{LUI_F5,  LW_X5,  1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[6]  = '{ADDI_U5, LW_X5,  1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1};
        vecs[7]  = '{ADDI_I5, LW_X5,  1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[8]  = '{SW_X5,   LW_X5,  1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1};
        vecs[9]  = '{BEQ_S1,  LW_X5,  1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1};
        vecs[10] = '{ADD_U5,  LW_X5,  1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[11] = '{NOP,     BEQ_S2, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1};
        vecs[12] = '{NOP,     BEQ_S2, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0};
        vecs[13] = '{NOP,     BEQ_S2, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1};
        vecs[14] = '{NOP,     BEQ_S2, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[15] = '{NOP,     JALR,   1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1};
        vecs[16] = '{JAL,     NOP,    1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0};
        vecs[17] = '{JAL,     JALR,   1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1};
        vecs[18] = '{JAL,     BEQ_S2, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1};
        vecs[19] = '{JAL,     JALR,   1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0};
        vecs[20] = '{JAL,     LW_X5,  1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0};
        vecs[21] = '{ADD_U5,  JALR,   1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1};

        // Reset and boot: rst sampled high on three edges, then RESET + 2 BOOT cycles.
        rst = 1'b1; cnt_clr = 1'b0; s3_valid = 1'b1;
        drive(NOP, NOP, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 3) rst = 1'b0;
            #1;
            check_ctl($sformatf("boot_ctl_%0d", k), 2'd3, 1'b1, 1'b1);
            check($sformatf("boot_flag_%0d", k), {31'd0, booting}, 32'd1);
            check($sformatf("boot_cycle_%0d", k), cycle_cnt, 32'd0);
            check($sformatf("boot_instret_%0d", k), instret_cnt, 32'd0);
        end
        @(negedge clk); s3_valid = 1'b0; #1;
        check_ctl("run_first", 2'd0, 1'b0, 1'b0);
        check("run_first_booting", {31'd0, booting}, 32'd0);
        @(negedge clk); #1;
        check("cycle_after_boot", cycle_cnt, 32'd1);
        check("instret_after_boot", instret_cnt, 32'd0);

        // Table of single-cycle RUN decisions; two idle cycles let any KILL drain.
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            drive(vecs[i].s1, vecs[i].s2, vecs[i].v, vecs[i].tk, vecs[i].pr);
            #1;
            check_ctl($sformatf("vec_%0d", i), vecs[i].pc, vecs[i].st, vecs[i].fl);
            @(negedge clk); drive(NOP, NOP, 1'b0, 1'b0, 1'b0);
            @(negedge clk); #1;
            check_ctl($sformatf("vec_%0d_settle", i), 2'd0, 1'b0, 1'b0);
        end

        // Load-use stalls once; with the bubble now in s2 the next cycle is clean.
        @(negedge clk); drive(ADD_U5, LW_X5, 1'b1, 1'b0, 1'b0); #1;
        check_ctl("lu_stall", 2'd0, 1'b1, 1'b1);
        @(negedge clk); drive(ADD_U5, NOP, 1'b0, 1'b0, 1'b0); #1;
        check_ctl("lu_after", 2'd0, 1'b0, 1'b0);

        // Mispredict: redirect, one KILL cycle ignoring a stale s1 JAL, then RUN.
        @(negedge clk); drive(NOP, BEQ_S2, 1'b1, 1'b1, 1'b0); #1;
        check_ctl("mp_n", 2'd1, 1'b0, 1'b1);
        @(negedge clk); drive(JAL, NOP, 1'b0, 1'b0, 1'b0); #1;
        check_ctl("mp_kill", 2'd0, 1'b0, 1'b1);
        @(negedge clk); drive(NOP, NOP, 1'b0, 1'b0, 1'b0); #1;
        check_ctl("mp_run", 2'd0, 1'b0, 1'b0);

        // s1 JAL also kills one fetch.
        @(negedge clk); drive(JAL, NOP, 1'b0, 1'b0, 1'b0); #1;
        check_ctl("jal_n", 2'd2, 1'b0, 1'b0);
        @(negedge clk); drive(NOP, NOP, 1'b0, 1'b0, 1'b0); #1;
        check_ctl("jal_kill", 2'd0, 1'b0, 1'b1);
        @(negedge clk); #1;
        check_ctl("jal_run", 2'd0, 1'b0, 1'b0);

        // Counters: clear wins over retire, then normal counting.
        @(negedge clk); cnt_clr = 1'b1; s3_valid = 1'b1;
        @(negedge clk); cnt_clr = 1'b0; #1;
        check("clr_cycle", cycle_cnt, 32'd0);
        check("clr_instret", instret_cnt, 32'd0);
        @(negedge clk); #1;
        check("cnt1_cycle", cycle_cnt, 32'd1);
        check("cnt1_instret", instret_cnt, 32'd1);
        @(negedge clk); s3_valid = 1'b0; #1;
        check("cnt2_cycle", cycle_cnt, 32'd2);
        check("cnt2_instret", instret_cnt, 32'd2);
        @(negedge clk); #1;
        check("cnt3_cycle", cycle_cnt, 32'd3);
        check("cnt3_instret", instret_cnt, 32'd2);

        // Wrap: preload all-ones, one RUN cycle with a retire wraps both.
        @(negedge clk);
        force dut.cycle_r = 32'hFFFFFFFF;
        force dut.instret_r = 32'hFFFFFFFF;
        #1;
        release dut.cycle_r;
        release dut.instret_r;
        s3_valid = 1'b1;
        check("preload_cycle", cycle_cnt, 32'hFFFFFFFF);
        @(negedge clk); #1;
        check("wrap_cycle", cycle_cnt, 32'd0);
        check("wrap_instret", instret_cnt, 32'd0);
        @(negedge clk); #1;
        check("post_wrap_instret", instret_cnt, 32'd1);
        cnt_clr = 1'b1;
        @(negedge clk); cnt_clr = 1'b0; s3_valid = 1'b0; #1;
        check("clr_retire_instret", instret_cnt, 32'd0);
        check("clr_retire_cycle", cycle_cnt, 32'd0);
        @(negedge clk); @(negedge clk); #1;
        check("count_resume", cycle_cnt, 32'd2);

        // Reset in the middle of KILL.
        @(negedge clk); drive(NOP, JALR, 1'b1, 1'b0, 1'b0);
        @(negedge clk); drive(NOP, NOP, 1'b0, 1'b0, 1'b0); rst = 1'b1; #1;
        check_ctl("rk_in_kill", 2'd0, 1'b0, 1'b1);
        @(negedge clk); rst = 1'b0; #1;
        check_ctl("rk_reset", 2'd3, 1'b1, 1'b1);
        check("rk_booting", {31'd0, booting}, 32'd1);
        check("rk_cycle", cycle_cnt, 32'd0);
        @(negedge clk); #1;
        check("rk_boot1", {31'd0, booting}, 32'd1);
        @(negedge clk); #1;
        check("rk_boot2", {31'd0, booting}, 32'd1);
        @(negedge clk); #1;
        check_ctl("rk_run", 2'd0, 1'b0, 1'b0);
        check("rk_run_booting", {31'd0, booting}, 32'd0);

        // Reset during a load-use stall.
        @(negedge clk); drive(ADD_U5, LW_X5, 1'b1, 1'b0, 1'b0); rst = 1'b1; #1;
        check_ctl("rs_stall", 2'd0, 1'b1, 1'b1);
        @(negedge clk); drive(NOP, NOP, 1'b0, 1'b0, 1'b0); rst = 1'b0; #1;
        check_ctl("rs_reset", 2'd3, 1'b1, 1'b1);
        check("rs_cycle", cycle_cnt, 32'd0);
        check("rs_instret", instret_cnt, 32'd0);
        @(negedge clk); @(negedge clk); @(negedge clk); #1;
        check_ctl("rs_run", 2'd0, 1'b0, 1'b0);
        @(negedge clk); drive(ADD_U5, LW_X5, 1'b1, 1'b0, 1'b0); #1;
        check_ctl("rs_stall_again", 2'd0, 1'b1, 1'b1);
        @(negedge clk); drive(NOP, NOP, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
